// File: rtl/ahblite_single_master.sv
// ----------------------------------------------------------------------------
// ahblite_single_master
//   Converts a simple valid/ready command port into single AHB-Lite transfers
//   with exactly one transfer in flight at a time. Misaligned or invalid-size
//   commands are rejected locally with an error response and no bus activity.
//
// Ports
//   HCLK, HRESET        clock, asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while IDLE, out of reset)
//   cmd_write/addr/size/wdata   command payload
//   rsp_valid/err/rdata single-cycle response, no backpressure
//   HADDR..HWDATA       AHB-Lite manager outputs
//   HRDATA/HREADY/HRESP AHB-Lite manager inputs (HREADY is system ready)
// ----------------------------------------------------------------------------
module ahblite_single_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_haddr, w_haddr_nxt;
  logic [1:0]  r_htrans, w_htrans_nxt;
  logic        r_hwrite, w_hwrite_nxt;
  logic [2:0]  r_hsize, w_hsize_nxt;
  logic [31:0] r_hwdata, w_hwdata_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic        r_rsp_err, w_rsp_err_nxt;
  logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;

  logic        w_accept;
  logic        w_reject;

  assign cmd_ready = (r_state == S_IDLE) && !HRESET;
  assign w_accept  = cmd_valid && cmd_ready;

  // Invalid size, or an address not aligned to the transfer size.
  assign w_reject  = (cmd_size == 2'b11) ||
                     ((cmd_size == 2'b01) && cmd_addr[0]) ||
                     ((cmd_size == 2'b10) && (cmd_addr[1:0] != 2'b00));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state     <= S_IDLE;
      r_haddr     <= '0;
      r_htrans    <= HTRANS_IDLE;
      r_hwrite    <= 1'b0;
      r_hsize     <= '0;
      r_hwdata    <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_haddr     <= w_haddr_nxt;
      r_htrans    <= w_htrans_nxt;
      r_hwrite    <= w_hwrite_nxt;
      r_hsize     <= w_hsize_nxt;
      r_hwdata    <= w_hwdata_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_haddr_nxt     = r_haddr;
    w_htrans_nxt    = r_htrans;
    w_hwrite_nxt    = r_hwrite;
    w_hsize_nxt     = r_hsize;
    w_hwdata_nxt    = r_hwdata;
    w_wdata_nxt     = r_wdata;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_rdata_nxt = '0;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_reject) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
          end else begin
            w_haddr_nxt  = cmd_addr;
            w_hwrite_nxt = cmd_write;
            w_hsize_nxt  = {1'b0, cmd_size};
            w_htrans_nxt = HTRANS_NONSEQ;
            w_wdata_nxt  = cmd_wdata;
            w_state_nxt  = S_ADDR;
          end
        end
      end

      S_ADDR: begin
        // With HREADY low the address phase is simply held.
        if (HREADY) begin
          w_htrans_nxt = HTRANS_IDLE;
          w_hwdata_nxt = r_hwrite ? r_wdata : '0;
          w_state_nxt  = S_DATA;
        end
      end

      S_DATA: begin
        // A first error cycle (HRESP=1, HREADY=0) just waits here; the
        // response is taken only on the completing HREADY=1 cycle.
        if (HREADY) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = HRESP;
          w_rsp_rdata_nxt = (!r_hwrite && !HRESP) ? HRDATA : '0;
          w_hwdata_nxt    = '0;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_htrans_nxt = HTRANS_IDLE;
        w_hwdata_nxt = '0;
      end
    endcase
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign HADDR     = r_haddr;
  assign HTRANS    = r_htrans;
  assign HWRITE    = r_hwrite;
  assign HSIZE     = r_hsize;
  assign HWDATA    = r_hwdata;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahblite_single_master.sv
// ----------------------------------------------------------------------------
// tb_ahblite_single_master
//   Directed stimulus with hand-computed expectations. The driver pushes the
//   expected response (and the expected bus transfer) into queues at command
//   acceptance; a subordinate model pops bus expectations and checks the
//   address/data phases, and a separate monitor pops and checks responses.
// ----------------------------------------------------------------------------
module tb_ahblite_single_master;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  ahblite_single_master #(.HPROT_VAL(4'b0011)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HPROT     (HPROT),
    .HMASTLOCK (HMASTLOCK),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  initial forever #5 HCLK = ~HCLK;

  int cyc = 0;
  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          aw;
    int          dw;
    logic        err;
    logic [31:0] rdata;
  } bus_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_htrans"},    {30'd0, HTRANS}, 32'd0);
    chk({tag, "_haddr"},     HADDR, 32'd0);
    chk({tag, "_hwrite"},    {31'd0, HWRITE}, 32'd0);
    chk({tag, "_hsize"},     {29'd0, HSIZE}, 32'd0);
    chk({tag, "_hwdata"},    HWDATA, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_err"},   {31'd0, rsp_err}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
  endtask

  // Subordinate model: decides HREADY/HRESP/HRDATA for the coming edge and
  // checks the manager outputs of the current cycle.
  int   sphase = 0;   // 0 none, 1 address phase, 2 data phase
  int   acnt = 0;
  int   dcnt = 0;
  bus_t cur;

  initial begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'hFFFF_0000;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        sphase = 0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
      end else if (sphase == 2) begin
        chk("data_htrans", {30'd0, HTRANS}, 32'd0);
        chk("data_hwdata", HWDATA, cur.wr ? cur.wdata : 32'd0);
        if (dcnt > 0) begin
          HREADY = 1'b0;
          HRESP  = cur.err && (dcnt == 1);
          dcnt--;
        end else begin
          HREADY = 1'b1;
          HRESP  = cur.err;
          HRDATA = cur.rdata;
          sphase = 0;
        end
      end else if (HTRANS == 2'b10) begin
        if (sphase == 0) begin
          if (bus_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_transfer: got NONSEQ to 0x%08h expected no transfer", HADDR);
            cur = '{wr: 1'b0, addr: HADDR, size: HSIZE, wdata: 32'd0, aw: 0, dw: 0, err: 1'b0, rdata: 32'd0};
          end else begin
            cur = bus_q.pop_front();
          end
          acnt   = cur.aw;
          sphase = 1;
        end
        chk("addr_haddr",  HADDR, cur.addr);
        chk("addr_hsize",  {29'd0, HSIZE}, {29'd0, cur.size});
        chk("addr_hwrite", {31'd0, HWRITE}, {31'd0, cur.wr});
        chk("addr_hwdata", HWDATA, 32'd0);
        chk("hburst",      {29'd0, HBURST}, 32'd0);
        chk("hprot",       {28'd0, HPROT}, 32'd3);
        chk("hmastlock",   {31'd0, HMASTLOCK}, 32'd0);
        HRESP = 1'b0;
        if (acnt > 0) begin
          HREADY = 1'b0;
          acnt--;
        end else begin
          HREADY = 1'b1;
          sphase = 2;
          dcnt   = cur.dw;
        end
      end else begin
        chk("idle_htrans", {30'd0, HTRANS}, 32'd0);
        chk("idle_hwdata", HWDATA, 32'd0);
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = 32'hFFFF_0000;
      end
    end
  end

  // Response monitor.
  rsp_t mon_e;
  initial forever begin
    @(negedge HCLK);
    if (rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got rsp err=%0b rdata=0x%08h expected none (cycle %0d)",
                 rsp_err, rsp_rdata, cyc);
      end else begin
        mon_e = rsp_q.pop_front();
        chk("rsp_err",   {31'd0, rsp_err}, {31'd0, mon_e.err});
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Called just after a rising edge. lat: cycles from acceptance to the
  // response cycle (1 = next cycle); 0 means no response is expected.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic [31:0] wdata, input int aw, input int dw,
                       input logic serr, input logic [31:0] srdata,
                       input logic exp_err, input logic [31:0] exp_rdata,
                       input int lat, input logic bus, input logic keep,
                       output int acc);
    bus_t b;
    rsp_t r;
    int   n;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    n = 0;
    @(negedge HCLK);
    while (cmd_ready !== 1'b1) begin
      n++;
      if (n > 50) begin
        vectors++;
        miscompares++;
        $display("FAIL cmd_accept_timeout: got no cmd_ready expected accept for addr 0x%08h", addr);
        cmd_valid = 1'b0;
        acc = -1;
        return;
      end
      @(negedge HCLK);
    end
    acc = cyc + 1;
    if (bus) begin
      b = '{wr: wr, addr: addr, size: {1'b0, size}, wdata: wdata, aw: aw, dw: dw,
            err: serr, rdata: srdata};
      bus_q.push_back(b);
    end
    if (lat > 0) begin
      r = '{err: exp_err, rdata: exp_rdata, cyc: acc + lat - 1};
      rsp_q.push_back(r);
    end
    @(posedge HCLK);
    #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  int acc;
  int acc1;
  int acc2;
  int n;

  initial begin
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_size  = '0;
    cmd_wdata = '0;

    #1 HRESET = 1'b1;
    #2 check_reset_outputs("reset");
    @(posedge HCLK);
    @(posedge HCLK);
    #2 HRESET = 1'b0;
    @(negedge HCLK);
    chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
    @(posedge HCLK);
    #1;

    // wr addr size wdata aw dw serr srdata | exp_err exp_rdata lat bus keep
    issue(1, 32'h4000_0000, 2'b10, 32'h0000_00A5, 0, 0, 0, 32'h1234_5678, 0, 32'h0, 3, 1, 0, acc);
    issue(0, 32'h4000_0003, 2'b00, 32'h0,         0, 2, 0, 32'h0000_0003, 0, 32'h3, 5, 1, 0, acc);
    issue(0, 32'h4000_0008, 2'b10, 32'h0,         0, 1, 1, 32'h7777_7777, 1, 32'h0, 4, 1, 0, acc);
    issue(1, 32'h4000_0002, 2'b10, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,         1, 32'h0, 1, 0, 0, acc);
    issue(0, 32'h4000_0000, 2'b11, 32'h0,         0, 0, 0, 32'h0,         1, 32'h0, 1, 0, 0, acc);
    issue(0, 32'h4000_0001, 2'b01, 32'h0,         0, 0, 0, 32'h0,         1, 32'h0, 1, 0, 0, acc);
    issue(1, 32'h4000_0012, 2'b01, 32'h0000_BEEF, 1, 1, 0, 32'hCAFE_0000, 0, 32'h0, 5, 1, 0, acc);
    issue(0, 32'h4000_0006, 2'b01, 32'h0,         0, 0, 0, 32'h0000_7788, 0, 32'h7788, 3, 1, 0, acc);
    issue(1, 32'h4000_0010, 2'b10, 32'h0102_0304, 0, 1, 1, 32'h0,         1, 32'h0, 4, 1, 0, acc);

    // Reset during a stalled data phase: no response, clean restart.
    issue(0, 32'h4000_0030, 2'b10, 32'h0, 0, 3, 0, 32'h5555_AAAA, 0, 32'h0, 0, 1, 0, acc);
    @(posedge HCLK);
    #4 HRESET = 1'b1;
    #1 check_reset_outputs("abort");
    repeat (3) @(posedge HCLK);
    #2 HRESET = 1'b0;
    @(negedge HCLK);
    chk("ready_after_abort", {31'd0, cmd_ready}, 32'd1);
    @(posedge HCLK);
    #1;
    issue(0, 32'h4000_0000, 2'b10, 32'h0, 0, 0, 0, 32'h1122_3344, 0, 32'h1122_3344, 3, 1, 0, acc);

    // Back-to-back with cmd_valid held high.
    issue(0, 32'h4000_0020, 2'b10, 32'h0, 0, 0, 0, 32'hA5A5_0001, 0, 32'hA5A5_0001, 3, 1, 1, acc1);
    issue(0, 32'h4000_0024, 2'b10, 32'h0, 0, 0, 0, 32'hA5A5_0002, 0, 32'hA5A5_0002, 3, 1, 0, acc2);
    chk("b2b_spacing", acc2 - acc1, 32'd3);

    n = 0;
    while (rsp_q.size() != 0 && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    #1;
    chk("pending_rsp", rsp_q.size(), 32'd0);
    chk("pending_bus", bus_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
